// File: rtl/xor_trigger.sv
// Bank of WIDTH independent T-type flip-flops: each bit toggles on every rising
// edge while its enable is high; synchronous active-high reset loads RST_VAL.
module xor_trigger_bit #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  // Reset wins over toggle at the same edge.
  always_ff @(posedge clk) begin
    if (rst) q <= RST_BIT;
    else     q <= q ^ t;
  end
endmodule

module xor_trigger #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  // rstn is active high despite its name; out comes straight from the flops.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    xor_trigger_bit #(.RST_BIT(RST_VAL[i])) u_bit (
      .clk (clk),
      .rst (rstn),
      .t   (in[i]),
      .q   (out[i])
    );
  end
endmodule

// File: tb/tb_xor_trigger.sv
// Scoreboarded random/directed bench for a 4-bit xor_trigger with RST_VAL=4'b1010.
module tb_xor_trigger;
  localparam int         W   = 4;
  localparam logic [3:0] RST = 4'b1010;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic [W-1:0] in = '0;
  logic [W-1:0] out;

  int compared = 0;
  int mismatched = 0;

  logic [W-1:0] expq[$];
  logic [W-1:0] model;
  string        tag = "init";

  xor_trigger #(.WIDTH(W), .RST_VAL(RST)) dut (
    .clk  (clk),
    .rstn (rstn),
    .in   (in),
    .out  (out)
  );

  always #10 clk = ~clk;

  // Reference: the value out must hold after the next rising edge, given the
  // levels of rstn and in that will be present at that edge.
  function automatic logic [W-1:0] next_val(input logic [W-1:0] cur,
                                            input logic r, input logic [W-1:0] t);
    logic [W-1:0] n;
    if (r) return RST;
    for (int b = 0; b < W; b++) n[b] = t[b] ? ~cur[b] : cur[b];
    return n;
  endfunction

  task automatic push_edge();
    model = next_val(model, rstn, in);
    expq.push_back(model);
  endtask

  // One edge of stimulus, applied at the falling edge before it.
  task automatic step(input logic r, input logic [W-1:0] t);
    @(negedge clk);
    rstn = r;
    in   = t;
    push_edge();
  endtask

  // Pulse on in (or rstn) from edge+5 to edge+15; must not reach out.
  task automatic glitch_in(input logic [W-1:0] g);
    @(posedge clk);
    #5  in = g;
    #10 in = '0;
    push_edge();
  endtask

  task automatic glitch_rst();
    @(posedge clk);
    #5  rstn = 1'b1;
    #10 rstn = 1'b0;
    in = '0;
    push_edge();
  endtask

  // Monitor: every edge that has an expectation queued is checked.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        logic [W-1:0] e;
        e = expq.pop_front();
        compared++;
        if (out !== e) begin
          mismatched++;
          $display("FAIL %s: out=%b expected=%b at %0t", tag, out, e, $time);
        end
      end
    end
  end

  initial begin
    model = RST;

    tag = "reset_idle";
    step(1'b1, '0);
    step(1'b1, '0);
    repeat (5) step(1'b0, '0);

    tag = "single_toggle";
    step(1'b0, 4'b0001);
    repeat (3) step(1'b0, '0);

    tag = "continuous_toggle";
    step(1'b1, '0);
    repeat (4) step(1'b0, 4'b1111);
    repeat (2) step(1'b0, '0);

    tag = "param_check";
    step(1'b1, '0);
    step(1'b0, 4'b0011);
    step(1'b0, '0);

    tag = "rst_priority";
    step(1'b0, 4'b0101);
    fork
      begin
        #13;
        repeat (8) begin
          in = ~in;
          #25;
        end
      end
      begin
        repeat (11) begin
          @(negedge clk);
          rstn = 1'b1;
          push_edge();
        end
      end
    join
    step(1'b0, '0);
    step(1'b0, 4'b0110);

    tag = "glitch";
    glitch_in(4'b1111);
    glitch_in(4'b0101);
    glitch_rst();
    step(1'b0, '0);

    tag = "random";
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 19))
        0:       step(1'b1, W'($urandom));
        1:       glitch_in(W'($urandom));
        2:       glitch_rst();
        default: step(1'b0, W'($urandom));
      endcase
    end

    tag = "drain";
    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (expq.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
